bram_ram_banked: RTL and testbench
==================================

Name: bram_ram_banked

Overview:
- Parametrised successor to the fixed 512x16 banked RAM.
- Generalised word width, depth and bank count; synchronous-read BRAM banks; registered read path with valid flag.
- Hardware clear sequencer zeroes the whole array after reset or on request, because BRAM contents are not touched by reset.
- Used as data RAM for the Hack CPU and as generic scratch storage in later projects.

Parameters:
- WIDTH, 16, data word width in bits.
- ADDR_W, 9, address width; depth = 2^ADDR_W words.
- BANK_BITS, 3, number of bank-select MSBs; banks = 2^BANK_BITS, each 2^(ADDR_W-BANK_BITS) deep. Legal range: 0 <= BANK_BITS < ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in  in  WIDTH  write data.
- address  in  ADDR_W  read/write address; bank = address[ADDR_W-1 -: BANK_BITS].
- load  in  1  write enable.
- rd_en  in  1  read request.
- clear  in  1  one-cycle pulse; starts a full-array zero fill.
- out  out  WIDTH  registered read data.
- out_valid  out  1  out holds data for the read issued the previous cycle.
- busy  out  1  clear sequence in progress.

Behaviour:
- Reset is asserted asynchronously: out=0, out_valid=0, busy=1, clear counter=0, FSM=CLEAR. Array contents are undefined until the clear completes.
- FSM CLEAR:
  - Each cycle, write 0 to address = counter, in the bank selected by the counter MSBs, then increment the counter.
  - After writing address 2^ADDR_W-1, go to IDLE next cycle and drop busy. Clear takes exactly 2^ADDR_W cycles after rst_n deasserts.
- FSM IDLE:
  - load=1 writes in to address at the clock edge. Exactly one bank write-enable is active (one-hot decode of the bank bits).
  - rd_en=1 gives out = mem[address] and out_valid=1 on the next edge. Latency is 1 cycle.
  - rd_en=0: out_valid=0 next cycle. out holds its last value (no toggling when idle).
  - The output mux uses the bank select registered alongside the read, not the live address.
- Read and write at the same address in the same cycle: read-first, so out returns the old contents. The new data is visible from the following read.
- Read and write at different addresses or banks in the same cycle: both take effect.
- clear while in IDLE: next cycle FSM=CLEAR, counter=0, busy=1.
- clear while in CLEAR: counter restarts at 0. The clear is not merged.
- While busy:
  - load and rd_en are ignored; no user write reaches the array.
  - out_valid=0; out keeps its value.
  - A read issued on the same cycle clear is sampled is dropped.
- rst_n asserted mid-clear or mid-read: immediate return to reset state; the clear restarts from address 0 after release.
- Address wrap: none. The counter is ADDR_W+1 bits wide internally, and its MSB marks completion.

Decomposition:
- Shared package bram_pkg:
  - FSM state enum {ST_CLEAR, ST_IDLE}.
  - Helper localparams: DEPTH, BANKS, BANK_DEPTH derived from the parameters.
- Sub-module bram_ram_bank:
  - Parameters WIDTH and BANK_ADDR_W.
  - Single port, synchronous read-first, with we, addr, din, dout.
  - Instantiated BANKS times in a generate loop.
- Top level holds the FSM, clear counter, one-hot write decode, registered bank select and output mux.

Test Plan:
- Reset release with default parameters: busy=1 for exactly 512 cycles, then 0. Read all 512 addresses: every out=0x0000, with out_valid pulsing one cycle after each rd_en.
- Write 0xBEEF to address 0x1C5 (bank 7), then read 0x1C5: out=0xBEEF one cycle later. Read 0x0C5 (bank 3): out=0x0000, which shows no bank aliasing.
- Write 0x1234 to 0x040, then in one cycle write 0x5678 to 0x040 with rd_en=1: out=0x1234 (read-first). A following read gives 0x5678.
- After filling memory with address-as-data, pulse clear, then 300 cycles later pulse clear again: busy stays high for 512 cycles from the second pulse. load pulses during busy are ignored, and the final readback is all zero.
- Assert rst_n low for 1 cycle at clear count 100: out=0, out_valid=0 immediately; the clear restarts and busy lasts 512 cycles after release.
- Parameter sweep with WIDTH=8, ADDR_W=4, BANK_BITS=0 and with WIDTH=32, ADDR_W=10, BANK_BITS=2: random write/read sequences match a scoreboard model, and clear length equals 2^ADDR_W.

Source files
------------

// File: rtl/bram_ram_banked_pkg.sv
// Shared types and sizing helpers for the banked block RAM.
package bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_ADDR_W    = 9;
  localparam int DEF_BANK_BITS = 3;

  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int BANKS      = 2 ** DEF_BANK_BITS;
  localparam int BANK_DEPTH = 2 ** (DEF_ADDR_W - DEF_BANK_BITS);

  function automatic int depth_of(input int addr_w);
    return 2 ** addr_w;
  endfunction

  function automatic int banks_of(input int bank_bits);
    return 2 ** bank_bits;
  endfunction

endpackage

// File: rtl/bram_ram_banked_bank.sv
// One single-port, read-first BRAM bank; dout updates only on a read so it holds between reads.
module bram_ram_bank #(
  parameter int WIDTH       = 16,
  parameter int BANK_ADDR_W = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic                   re,
  input  logic [BANK_ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout
);

  logic [WIDTH-1:0] mem [2**BANK_ADDR_W];
  logic [WIDTH-1:0] dout_q, dout_d;

  // Array has no reset so it maps onto block RAM; the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
  end

  always_comb begin
    dout_d = dout_q;
    if (re) dout_d = mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout_q <= '0;
    else        dout_q <= dout_d;
  end

  assign dout = dout_q;

endmodule

// File: rtl/bram_ram_banked.sv
// Parametrised banked RAM: clear sequencer, one-hot bank write decode, 1-cycle registered read.
module bram_ram_banked
  import bram_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 9,
  parameter int BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int N_BANKS = banks_of(BANK_BITS);
  localparam int BANK_AW = ADDR_W - BANK_BITS;
  localparam int BSEL_W  = (BANK_BITS > 0) ? BANK_BITS : 1;
  localparam int N_SLOTS = 2 ** BSEL_W;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [BSEL_W-1:0] sel_q, sel_d;

  logic [BSEL_W-1:0]  addr_bank, cnt_bank, wr_bank;
  logic [BANK_AW-1:0] bank_addr;
  logic [WIDTH-1:0]   bank_din;
  logic               wr_en, rd_fire;
  logic [WIDTH-1:0]   bank_dout [N_SLOTS];

  generate
    if (BANK_BITS > 0) begin : g_bank_sel
      assign addr_bank = address[ADDR_W-1 -: BSEL_W];
      assign cnt_bank  = cnt_q[ADDR_W-1 -: BSEL_W];
    end else begin : g_single_bank
      assign addr_bank = '0;
      assign cnt_bank  = '0;
    end
  endgenerate

  // The counter carries one extra bit: its MSB rising means the last word was just zeroed.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    rd_fire     = 1'b0;
    wr_bank     = addr_bank;
    bank_addr   = address[BANK_AW-1:0];
    bank_din    = in;
    case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        wr_bank   = cnt_bank;
        bank_addr = cnt_q[BANK_AW-1:0];
        bank_din  = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_d[ADDR_W]) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        wr_en   = load;
        rd_fire = rd_en;
      end
      default: state_d = ST_CLEAR;
    endcase
    // A clear request wins over any user access sampled with it.
    if (clear) begin
      state_d = ST_CLEAR;
      cnt_d   = '0;
      rd_fire = 1'b0;
      if (state_q == ST_IDLE) wr_en = 1'b0;
    end
    sel_d       = rd_fire ? addr_bank : sel_q;
    out_valid_d = rd_fire;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      sel_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      sel_q       <= sel_d;
    end
  end

  generate
    for (genvar i = 0; i < N_BANKS; i++) begin : g_banks
      logic bank_we;
      assign bank_we = wr_en && (wr_bank == BSEL_W'(i));
      bram_ram_bank #(
        .WIDTH      (WIDTH),
        .BANK_ADDR_W(BANK_AW)
      ) u_bank (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (bank_we),
        .re   (rd_fire),
        .addr (bank_addr),
        .din  (bank_din),
        .dout (bank_dout[i])
      );
    end
    for (genvar j = N_BANKS; j < N_SLOTS; j++) begin : g_pad
      assign bank_dout[j] = '0;
    end
  endgenerate

  // Mux by the bank captured with the read, so address changes after the read cannot disturb out.
  assign out       = bank_dout[sel_q];
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_bram_ram_banked.sv
// Directed bench for bram_ram_banked: default instance plus two parameter-sweep instances.
module tb_bram_ram_banked;

  logic clk;
  logic rst_n;

  logic [15:0] in_d;
  logic [8:0]  addr_d;
  logic        load_d, rd_d, clear_d;
  logic [15:0] out_d;
  logic        ov_d, busy_d;

  logic [7:0]  in_s;
  logic [3:0]  addr_s;
  logic        load_s, rd_s, clear_s;
  logic [7:0]  out_s;
  logic        ov_s, busy_s;

  logic [31:0] in_l;
  logic [9:0]  addr_l;
  logic        load_l, rd_l, clear_l;
  logic [31:0] out_l;
  logic        ov_l, busy_l;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        load;
    logic        rd;
    logic [8:0]  addr;
    logic [15:0] din;
    logic        exp_valid;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs[12];

  logic [7:0]  mem_s [16];
  logic [31:0] mem_l [1024];
  logic [7:0]  exp_s_q[$];
  logic [31:0] exp_l_q[$];

  bram_ram_banked dut (
    .clk(clk), .rst_n(rst_n), .in(in_d), .address(addr_d), .load(load_d),
    .rd_en(rd_d), .clear(clear_d), .out(out_d), .out_valid(ov_d), .busy(busy_d)
  );

  bram_ram_banked #(.WIDTH(8), .ADDR_W(4), .BANK_BITS(0)) dut_s (
    .clk(clk), .rst_n(rst_n), .in(in_s), .address(addr_s), .load(load_s),
    .rd_en(rd_s), .clear(clear_s), .out(out_s), .out_valid(ov_s), .busy(busy_s)
  );

  bram_ram_banked #(.WIDTH(32), .ADDR_W(10), .BANK_BITS(2)) dut_l (
    .clk(clk), .rst_n(rst_n), .in(in_l), .address(addr_l), .load(load_l),
    .rd_en(rd_l), .clear(clear_l), .out(out_l), .out_valid(ov_l), .busy(busy_l)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    load_d = 0; rd_d = 0; clear_d = 0; in_d = '0; addr_d = '0;
    load_s = 0; rd_s = 0; clear_s = 0; in_s = '0; addr_s = '0;
    load_l = 0; rd_l = 0; clear_l = 0; in_l = '0; addr_l = '0;
  endtask

  task automatic read_d(input logic [8:0] a, input logic [15:0] exp, input string name);
    addr_d = a; rd_d = 1;
    step();
    rd_d = 0;
    check({name, "_valid"}, {31'd0, ov_d}, 32'd1);
    check(name, {16'd0, out_d}, {16'd0, exp});
  endtask

  // Steps until the default DUT drops busy; returns step count (bounded).
  task automatic wait_idle_d(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (busy_d && n < 2000);
  endtask

  initial begin
    int bd, bs, bl, n, bad_valid, bad_busy, bad_hold, bad_zero;
    logic [15:0] held;

    vecs[0]  = '{1'b1, 1'b0, 9'h1C5, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 9'h0C5, 16'h0000, 1'b1, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 9'h1C5, 16'h0000, 1'b1, 16'hBEEF};
    vecs[3]  = '{1'b0, 1'b0, 9'h1C5, 16'h0000, 1'b0, 16'hBEEF};
    vecs[4]  = '{1'b1, 1'b0, 9'h040, 16'h1234, 1'b0, 16'hBEEF};
    vecs[5]  = '{1'b1, 1'b1, 9'h040, 16'h5678, 1'b1, 16'h1234};
    vecs[6]  = '{1'b0, 1'b1, 9'h040, 16'h0000, 1'b1, 16'h5678};
    vecs[7]  = '{1'b1, 1'b1, 9'h1FF, 16'hA5A5, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 9'h1FF, 16'h0000, 1'b1, 16'hA5A5};
    vecs[9]  = '{1'b0, 1'b0, 9'h000, 16'h0000, 1'b0, 16'hA5A5};
    vecs[10] = '{1'b0, 1'b1, 9'h0C5, 16'h0000, 1'b1, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 9'h1C5, 16'h0000, 1'b1, 16'hBEEF};

    for (int i = 0; i < 16; i++) mem_s[i] = '0;
    for (int i = 0; i < 1024; i++) mem_l[i] = '0;

    // Reset state and clear length for all three parameter sets
    rst_n = 0;
    idle_inputs();
    step();
    step();
    check("rst_out", {16'd0, out_d}, 32'd0);
    check("rst_valid", {31'd0, ov_d}, 32'd0);
    check("rst_busy", {31'd0, busy_d}, 32'd1);
    check("rst_busy_s", {31'd0, busy_s}, 32'd1);
    check("rst_busy_l", {31'd0, busy_l}, 32'd1);
    rst_n = 1;
    bd = 0; bs = 0; bl = 0;
    for (int c = 1; c <= 1100; c++) begin
      step();
      if (!busy_d && bd == 0) bd = c;
      if (!busy_s && bs == 0) bs = c;
      if (!busy_l && bl == 0) bl = c;
    end
    check("clear_len_default", bd, 512);
    check("clear_len_small", bs, 16);
    check("clear_len_large", bl, 1024);

    // Full readback after power-up clear
    bad_valid = 0; bad_zero = 0;
    for (int a = 0; a < 512; a++) begin
      addr_d = 9'(a); rd_d = 1;
      step();
      if (ov_d !== 1'b1) bad_valid++;
      if (out_d !== 16'h0000) bad_zero++;
    end
    rd_d = 0;
    step();
    check("init_readback_valid_errs", bad_valid, 0);
    check("init_readback_zero_errs", bad_zero, 0);
    check("valid_drops", {31'd0, ov_d}, 32'd0);

    // Table-driven IDLE vectors: bank aliasing, read-first, hold
    for (int i = 0; i < 12; i++) begin
      load_d = vecs[i].load; rd_d = vecs[i].rd;
      addr_d = vecs[i].addr; in_d = vecs[i].din;
      step();
      check($sformatf("vec%0d_valid", i), {31'd0, ov_d}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_out", i), {16'd0, out_d}, {16'd0, vecs[i].exp_out});
    end
    idle_inputs();

    // Parameter sweep: random traffic against scoreboard models
    for (int i = 0; i < 300; i++) begin
      load_s = 1'($urandom_range(0, 1)); rd_s = 1'($urandom_range(0, 1));
      addr_s = 4'($urandom_range(0, 15)); in_s = 8'($urandom_range(0, 255));
      load_l = 1'($urandom_range(0, 1)); rd_l = 1'($urandom_range(0, 1));
      addr_l = 10'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      in_l = $urandom;
      if (rd_s) exp_s_q.push_back(mem_s[addr_s]);
      if (load_s) mem_s[addr_s] = in_s;
      if (rd_l) exp_l_q.push_back(mem_l[addr_l]);
      if (load_l) mem_l[addr_l] = in_l;
      step();
      check("sweep_s_valid", {31'd0, ov_s}, {31'd0, rd_s});
      check("sweep_l_valid", {31'd0, ov_l}, {31'd0, rd_l});
      if (rd_s && exp_s_q.size() > 0) check("sweep_s_data", {24'd0, out_s}, {24'd0, exp_s_q.pop_front()});
      if (rd_l && exp_l_q.size() > 0) check("sweep_l_data", out_l, exp_l_q.pop_front());
    end
    idle_inputs();
    clear_s = 1; clear_l = 1;
    step();
    clear_s = 0; clear_l = 0;
    bs = 0; bl = 0;
    for (int c = 1; c <= 1100; c++) begin
      step();
      if (!busy_s && bs == 0) bs = c;
      if (!busy_l && bl == 0) bl = c;
    end
    check("reclear_len_small", bs, 16);
    check("reclear_len_large", bl, 1024);

    // Fill default DUT with address-as-data
    for (int a = 0; a < 512; a++) begin
      load_d = 1; addr_d = 9'(a); in_d = 16'(a);
      step();
    end
    load_d = 0;
    read_d(9'h1C5, 16'h01C5, "fill_1c5");
    read_d(9'h040, 16'h0040, "fill_040");
    read_d(9'h0C5, 16'h00C5, "fill_0c5");
    read_d(9'h1FF, 16'h01FF, "fill_1ff");
    held = 16'h01FF;

    // Clear sampled with a read and a write: both dropped
    clear_d = 1; rd_d = 1; load_d = 1; addr_d = 9'h1C5; in_d = 16'h7777;
    step();
    clear_d = 0;
    check("clear_drops_read", {31'd0, ov_d}, 32'd0);
    check("clear_busy", {31'd0, busy_d}, 32'd1);
    bad_valid = 0; bad_busy = 0; bad_hold = 0;
    for (int c = 0; c < 299; c++) begin
      load_d = 1'($urandom_range(0, 1)); rd_d = 1'($urandom_range(0, 1));
      addr_d = 9'($urandom_range(0, 511)); in_d = 16'hFFFF;
      step();
      if (ov_d !== 1'b0) bad_valid++;
      if (busy_d !== 1'b1) bad_busy++;
      if (out_d !== held) bad_hold++;
    end
    // Second clear restarts the counter
    clear_d = 1; load_d = 0; rd_d = 0;
    step();
    clear_d = 0;
    n = 0;
    while (busy_d && n < 2000) begin
      load_d = 1'($urandom_range(0, 1)); rd_d = 1'($urandom_range(0, 1));
      addr_d = 9'($urandom_range(0, 511)); in_d = 16'hFFFF;
      step();
      n++;
      if (busy_d && ov_d !== 1'b0) bad_valid++;
      if (busy_d && out_d !== held) bad_hold++;
    end
    idle_inputs();
    check("busy_ignores_read_errs", bad_valid, 0);
    check("busy_stays_high_errs", bad_busy, 0);
    check("busy_out_hold_errs", bad_hold, 0);
    check("second_clear_len", n, 512);
    bad_zero = 0;
    for (int a = 0; a < 512; a++) begin
      addr_d = 9'(a); rd_d = 1;
      step();
      if (out_d !== 16'h0000 || ov_d !== 1'b1) bad_zero++;
    end
    rd_d = 0;
    step();
    check("post_clear_zero_errs", bad_zero, 0);

    // Reset asserted mid-clear
    load_d = 1; addr_d = 9'h003; in_d = 16'h4321;
    step();
    load_d = 0;
    read_d(9'h003, 16'h4321, "pre_reset_read");
    clear_d = 1;
    step();
    clear_d = 0;
    for (int c = 0; c < 100; c++) step();
    rst_n = 0;
    #1;
    check("async_rst_out", {16'd0, out_d}, 32'd0);
    check("async_rst_valid", {31'd0, ov_d}, 32'd0);
    check("async_rst_busy", {31'd0, busy_d}, 32'd1);
    step();
    rst_n = 1;
    wait_idle_d(n);
    check("reset_clear_len", n, 512);
    read_d(9'h003, 16'h0000, "post_reset_read");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the bench cannot hang
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
